// File: rtl/hist_pkg.sv
// hist_pkg: shared constants and address helper for the event-history block.
//   HIST_ENTRIES_PER_LP / HIST_OFF_W : each LP owns 16 consecutive history words
//   HIST_SIZE_W / HIST_SIZE_MAX      : per-LP valid-entry counter width and ceiling
//   hist_mk_addr(lp, off)            : builds {lp, off}; callers truncate to AW
package hist_pkg;

    localparam int               HIST_ENTRIES_PER_LP = 16;
    localparam int               HIST_OFF_W          = 4;
    localparam int               HIST_SIZE_W         = 4;
    localparam logic [HIST_SIZE_W-1:0] HIST_SIZE_MAX = 4'd15;

    function automatic logic [15:0] hist_mk_addr(input logic [11:0] lp,
                                                 input logic [HIST_OFF_W-1:0] off);
        return {lp, off};
    endfunction

endpackage

// File: rtl/hist_ram.sv
// hist_ram: single-port synchronous RAM, write-first, one-cycle read latency.
//   clk_i   : clock
//   en_i    : access enable (read or write)
//   we_i    : write qualifier
//   addr_i  : word address
//   wdata_i : write data
//   rdata_o : registered read data (write-first: shows wdata_i on a write)
// Contents are not reset.
module hist_ram #(
    parameter int AW = 8,
    parameter int DW = 32
) (
    input  logic          clk_i,
    input  logic          en_i,
    input  logic          we_i,
    input  logic [AW-1:0] addr_i,
    input  logic [DW-1:0] wdata_i,
    output logic [DW-1:0] rdata_o
);

    logic [DW-1:0] mem_q [2**AW];
    logic [DW-1:0] rdata_q;

    always_ff @(posedge clk_i) begin
        if (en_i) begin
            if (we_i) begin
                mem_q[addr_i] <= wdata_i;
                rdata_q       <= wdata_i;
            end else begin
                rdata_q       <= mem_q[addr_i];
            end
        end
    end

    assign rdata_o = rdata_q;

endmodule

// File: rtl/hist_arbiter.sv
// hist_arbiter: round-robin arbiter sharing one history RAM among NCORES cores.
//   clk, rst (sync, active-high)
//   hist_rq/hist_wr_en/hist_addr/hist_data_wr : per-core request bundles
//   hist_access_grant : one-hot combinational grant (zero in reset)
//   hist_data_rd/hist_rd_vld/hist_rd_core     : broadcast read return, 1 cycle after grant
//   hist_size  : per-core size of the LP addressed by that core (combinational)
//   hist_clr/hist_clr_lp : zero one LP's size counter
module hist_arbiter
    import hist_pkg::*;
#(
    parameter int NCORES = 4,
    parameter int NCB    = 2,
    parameter int NIDB   = 3,
    parameter int AW     = 8,
    parameter int DW     = 32
) (
    input  logic                          clk,
    input  logic                          rst,
    input  logic [NCORES-1:0]             hist_rq,
    input  logic [NCORES-1:0]             hist_wr_en,
    input  logic [NCORES*AW-1:0]          hist_addr,
    input  logic [NCORES*DW-1:0]          hist_data_wr,
    output logic [NCORES-1:0]             hist_access_grant,
    output logic [DW-1:0]                 hist_data_rd,
    output logic                          hist_rd_vld,
    output logic [NCB-1:0]                hist_rd_core,
    output logic [NCORES*HIST_SIZE_W-1:0] hist_size,
    input  logic                          hist_clr,
    input  logic [NIDB-1:0]               hist_clr_lp
);

    localparam int NLP = 1 << NIDB;

    logic [NCB-1:0]         last_q;
    logic [NCB-1:0]         gidx;
    logic [NCB-1:0]         cand;
    logic [NCORES-1:0]      gnt;
    logic                   gnt_any;

    logic [AW-1:0]          sel_addr;
    logic [DW-1:0]          sel_wdata;
    logic                   sel_we;
    logic [NIDB-1:0]        sel_lp;
    logic [HIST_OFF_W-1:0]  sel_off;
    logic [HIST_SIZE_W-1:0] wr_size;
    logic                   wr_fire;
    logic                   rd_fire;

    logic [HIST_SIZE_W-1:0] size_q [NLP];
    logic [HIST_SIZE_W-1:0] size_d [NLP];

    logic                   rd_vld_q;
    logic [NCB-1:0]         rd_core_q;
    logic [DW-1:0]          hold_q;
    logic [DW-1:0]          ram_rdata;

    // Scan last+1 .. last+NCORES; NCORES is a power of two so NCB-bit
    // wrap-around gives the modulo for free.
    always_comb begin
        gnt     = '0;
        gidx    = last_q;
        gnt_any = 1'b0;
        cand    = '0;
        for (int k = 1; k <= NCORES; k++) begin
            cand = last_q + NCB'(k);
            if (!gnt_any && hist_rq[cand]) begin
                gnt_any   = 1'b1;
                gidx      = cand;
                gnt[cand] = 1'b1;
            end
        end
        if (rst) begin
            gnt     = '0;
            gnt_any = 1'b0;
        end
    end

    assign hist_access_grant = gnt;

    assign sel_addr  = hist_addr[gidx*AW +: AW];
    assign sel_wdata = hist_data_wr[gidx*DW +: DW];
    assign sel_we    = hist_wr_en[gidx];
    assign sel_lp    = sel_addr[HIST_OFF_W +: NIDB];
    assign sel_off   = sel_addr[HIST_OFF_W-1:0];
    assign wr_fire   = gnt_any & sel_we;
    assign rd_fire   = gnt_any & ~sel_we;

    // Size after writing offset off is off+1, capped so offset 15 stays at 15.
    assign wr_size = (sel_off == HIST_OFF_W'(HIST_ENTRIES_PER_LP - 1))
                   ? HIST_SIZE_MAX : HIST_SIZE_W'(sel_off) + HIST_SIZE_W'(1);

    hist_ram #(.AW(AW), .DW(DW)) u_ram (
        .clk_i   (clk),
        .en_i    (gnt_any),
        .we_i    (sel_we),
        .addr_i  (sel_addr),
        .wdata_i (sel_wdata),
        .rdata_o (ram_rdata)
    );

    // Clear is applied first so a same-cycle write to that LP lands on zero.
    always_comb begin
        for (int l = 0; l < NLP; l++) begin
            size_d[l] = size_q[l];
            if (hist_clr && hist_clr_lp == NIDB'(l))
                size_d[l] = '0;
            if (wr_fire && sel_lp == NIDB'(l) && wr_size > size_d[l])
                size_d[l] = wr_size;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            last_q    <= NCB'(NCORES - 1);
            rd_vld_q  <= 1'b0;
            rd_core_q <= '0;
            hold_q    <= '0;
            for (int l = 0; l < NLP; l++) size_q[l] <= '0;
        end else begin
            if (gnt_any) last_q <= gidx;
            rd_vld_q <= rd_fire;
            if (rd_fire) rd_core_q <= gidx;
            // Latch returned data so the bus keeps it once the RAM moves on.
            if (rd_vld_q) hold_q <= ram_rdata;
            for (int l = 0; l < NLP; l++) size_q[l] <= size_d[l];
        end
    end

    for (genvar c = 0; c < NCORES; c++) begin : g_size
        assign hist_size[c*HIST_SIZE_W +: HIST_SIZE_W] =
            size_q[hist_addr[c*AW + HIST_OFF_W +: NIDB]];
    end

    // A read in flight when reset arrives must not show up as valid.
    assign hist_rd_vld  = rd_vld_q & ~rst;
    assign hist_rd_core = rst ? '0 : rd_core_q;
    assign hist_data_rd = rst ? '0 : (rd_vld_q ? ram_rdata : hold_q);

endmodule

// File: tb/tb_hist_arbiter.sv
module tb_hist_arbiter;
    import hist_pkg::*;

    localparam int NCORES = 4;
    localparam int NCB    = 2;
    localparam int NIDB   = 3;
    localparam int AW     = 8;
    localparam int DW     = 32;

    logic                   clk;
    logic                   rst;
    logic [NCORES-1:0]      hist_rq;
    logic [NCORES-1:0]      hist_wr_en;
    logic [NCORES*AW-1:0]   hist_addr;
    logic [NCORES*DW-1:0]   hist_data_wr;
    logic [NCORES-1:0]      hist_access_grant;
    logic [DW-1:0]          hist_data_rd;
    logic                   hist_rd_vld;
    logic [NCB-1:0]         hist_rd_core;
    logic [NCORES*4-1:0]    hist_size;
    logic                   hist_clr;
    logic [NIDB-1:0]        hist_clr_lp;

    hist_arbiter #(.NCORES(NCORES), .NCB(NCB), .NIDB(NIDB), .AW(AW), .DW(DW)) dut (
        .clk               (clk),
        .rst               (rst),
        .hist_rq           (hist_rq),
        .hist_wr_en        (hist_wr_en),
        .hist_addr         (hist_addr),
        .hist_data_wr      (hist_data_wr),
        .hist_access_grant (hist_access_grant),
        .hist_data_rd      (hist_data_rd),
        .hist_rd_vld       (hist_rd_vld),
        .hist_rd_core      (hist_rd_core),
        .hist_size         (hist_size),
        .hist_clr          (hist_clr),
        .hist_clr_lp       (hist_clr_lp)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    typedef struct {
        int            core;
        logic [DW-1:0] data;
    } rd_exp_t;

    rd_exp_t         sb[$];
    rd_exp_t         sb_e;
    logic [DW-1:0]   mem_m [int];
    logic [3:0]      sz_m [8];
    int              checks = 0;
    int              errors = 0;

    function automatic logic [AW-1:0] mk(input int lp, input int off);
        return AW'(hist_mk_addr(12'(lp), 4'(off)));
    endfunction

    // Read-return scoreboard: every valid return must match the oldest expected read.
    always @(negedge clk) begin
        if (hist_rd_vld === 1'b1) begin
            checks++;
            if (sb.size() == 0) begin
                errors++;
                $display("FAIL rd_unexpected core=%0d data=%h, required no read return",
                         hist_rd_core, hist_data_rd);
            end else begin
                sb_e = sb.pop_front();
                if (hist_rd_core !== NCB'(sb_e.core) || hist_data_rd !== sb_e.data) begin
                    errors++;
                    $display("FAIL rd_return got core=%0d data=%h, required core=%0d data=%h",
                             hist_rd_core, hist_data_rd, sb_e.core, sb_e.data);
                end
            end
        end
    end

    // Single uncontended access from one core; updates the reference models.
    task automatic issue(input int core, input bit we, input logic [AW-1:0] a,
                         input logic [DW-1:0] d, input bit clr = 1'b0, input int clr_lp = 0);
        logic [NCORES-1:0] exp_g;
        logic [4:0]        nsz;
        rd_exp_t           e;
        hist_rq                       = '0;
        hist_rq[core]                 = 1'b1;
        hist_wr_en[core]              = we;
        hist_addr[core*AW +: AW]      = a;
        hist_data_wr[core*DW +: DW]   = d;
        hist_clr                      = clr;
        hist_clr_lp                   = NIDB'(clr_lp);
        #1;
        checks++;
        exp_g = NCORES'(1) << core;
        if (hist_access_grant !== exp_g) begin
            errors++;
            $display("FAIL issue_grant core=%0d got %b, required %b", core, hist_access_grant, exp_g);
        end
        if (clr) sz_m[clr_lp] = 4'd0;
        if (we) begin
            mem_m[int'(a)] = d;
            nsz = {1'b0, a[3:0]} + 5'd1;
            if (nsz > 5'd15) nsz = 5'd15;
            if (nsz[3:0] > sz_m[a[6:4]]) sz_m[a[6:4]] = nsz[3:0];
        end else begin
            e.core = core;
            e.data = mem_m[int'(a)];
            sb.push_back(e);
        end
        @(posedge clk); #1;
        hist_rq  = '0;
        hist_clr = 1'b0;
    endtask

    task automatic test_reset();
        rst     = 1'b1;
        hist_rq = '1;
        repeat (2) @(posedge clk);
        #1;
        checks++;
        if (hist_access_grant !== 4'b0000) begin
            errors++; $display("FAIL reset_grant got %b, required 0000", hist_access_grant);
        end
        checks++;
        if (hist_rd_vld !== 1'b0 || hist_rd_core !== 2'd0 || hist_data_rd !== 32'd0) begin
            errors++;
            $display("FAIL reset_rd got vld=%b core=%0d data=%h, required 0/0/0",
                     hist_rd_vld, hist_rd_core, hist_data_rd);
        end
        checks++;
        if (hist_size !== 16'h0000) begin
            errors++; $display("FAIL reset_size got %h, required 0000", hist_size);
        end
        rst     = 1'b0;
        hist_rq = '0;
        for (int l = 0; l < 8; l++) sz_m[l] = 4'd0;
    endtask

    task automatic test_two_req();
        hist_wr_en                = 4'b0101;
        hist_addr[0*AW +: AW]     = mk(0, 0);
        hist_addr[2*AW +: AW]     = mk(4, 1);
        hist_data_wr[0*DW +: DW]  = 32'h0000_0011;
        hist_data_wr[2*DW +: DW]  = 32'h0000_0022;
        hist_rq                   = 4'b0101;
        #1;
        checks++;
        if (hist_access_grant !== 4'b0001) begin
            errors++; $display("FAIL pair_first got %b, required 0001", hist_access_grant);
        end
        mem_m[int'(mk(0, 0))] = 32'h0000_0011; sz_m[0] = 4'd1;
        @(posedge clk); #1;
        hist_rq[0] = 1'b0;
        #1;
        checks++;
        if (hist_access_grant !== 4'b0100) begin
            errors++; $display("FAIL pair_second got %b, required 0100", hist_access_grant);
        end
        mem_m[int'(mk(4, 1))] = 32'h0000_0022; sz_m[4] = 4'd2;
        @(posedge clk); #1;
        hist_rq = '0;
        checks++;
        if (hist_size[0 +: 4] !== 4'd1 || hist_size[8 +: 4] !== 4'd2) begin
            errors++;
            $display("FAIL pair_size got c0=%0d c2=%0d, required 1 and 2",
                     hist_size[0 +: 4], hist_size[8 +: 4]);
        end
        // last is now 2: with everyone asking, core 3 is next in line.
        hist_wr_en = '0;
        hist_rq    = '1;
        #1;
        checks++;
        if (hist_access_grant !== 4'b1000) begin
            errors++; $display("FAIL pair_last got %b, required 1000", hist_access_grant);
        end
        hist_rq = '0;
        issue(3, 1'b1, mk(6, 0), 32'h0000_0033);
    endtask

    task automatic test_fairness();
        int          order [8] = '{0, 1, 2, 3, 0, 1, 2, 3};
        logic [3:0]  exp_g;
        int          g;
        for (int i = 0; i < NCORES; i++) begin
            hist_addr[i*AW +: AW]    = mk(7, i);
            hist_data_wr[i*DW +: DW] = 32'hF000_0000 | DW'(i);
        end
        hist_wr_en = '1;
        hist_rq    = '1;
        for (int cyc = 0; cyc < 8; cyc++) begin
            #1;
            g     = order[cyc];
            exp_g = 4'b0001 << g;
            checks++;
            if (hist_access_grant !== exp_g) begin
                errors++;
                $display("FAIL rr_cycle%0d got %b, required %b", cyc, hist_access_grant, exp_g);
            end
            mem_m[int'(mk(7, g))] = 32'hF000_0000 | DW'(g);
            if (4'(g + 1) > sz_m[7]) sz_m[7] = 4'(g + 1);
            @(posedge clk); #1;
        end
        hist_rq = '0;
        checks++;
        if (hist_size[0 +: 4] !== 4'd4) begin
            errors++; $display("FAIL rr_size got %0d, required 4", hist_size[0 +: 4]);
        end
    endtask

    task automatic test_write_read();
        issue(1, 1'b1, 8'h32, 32'hA5A5_0001);
        checks++;
        if (hist_size[4 +: 4] !== 4'd3) begin
            errors++; $display("FAIL wr_size got %0d, required 3", hist_size[4 +: 4]);
        end
        issue(1, 1'b0, 8'h32, 32'h0);
        checks++;
        if (hist_rd_vld !== 1'b1) begin
            errors++; $display("FAIL rd_vld got %b, required 1", hist_rd_vld);
        end
        @(posedge clk); #1;
        checks++;
        if (hist_rd_vld !== 1'b0 || hist_data_rd !== 32'hA5A5_0001) begin
            errors++;
            $display("FAIL rd_hold got vld=%b data=%h, required 0/a5a50001", hist_rd_vld, hist_data_rd);
        end
        // Back-to-back write then read of the same word returns the new value.
        issue(2, 1'b1, mk(1, 7), 32'hCAFE_F00D);
        issue(0, 1'b0, mk(1, 7), 32'h0);
    endtask

    task automatic test_saturation();
        for (int o = 0; o < 16; o++) begin
            issue(2, 1'b1, mk(5, o), 32'h5500_0000 | DW'(o));
            checks++;
            if (hist_size[8 +: 4] !== sz_m[5] || hist_size[8 +: 4] !== ((o == 15) ? 4'd15 : 4'(o + 1))) begin
                errors++;
                $display("FAIL sat_off%0d got %0d, required %0d", o, hist_size[8 +: 4], sz_m[5]);
            end
        end
        hist_clr    = 1'b1;
        hist_clr_lp = 3'd5;
        @(posedge clk); #1;
        hist_clr = 1'b0;
        sz_m[5]  = 4'd0;
        checks++;
        if (hist_size[8 +: 4] !== 4'd0) begin
            errors++; $display("FAIL sat_clr got %0d, required 0", hist_size[8 +: 4]);
        end
        issue(2, 1'b1, mk(5, 3), 32'h1);
        issue(2, 1'b1, mk(5, 1), 32'h2);
        checks++;
        if (hist_size[8 +: 4] !== 4'd4) begin
            errors++; $display("FAIL sat_nodec got %0d, required 4", hist_size[8 +: 4]);
        end
    endtask

    task automatic test_clr_collision();
        issue(0, 1'b1, mk(2, 9), 32'h2200_0009);
        checks++;
        if (hist_size[0 +: 4] !== 4'd10) begin
            errors++; $display("FAIL coll_pre got %0d, required 10", hist_size[0 +: 4]);
        end
        issue(0, 1'b1, mk(2, 3), 32'h2200_0003, 1'b1, 2);
        checks++;
        if (hist_size[0 +: 4] !== 4'd4 || sz_m[2] !== 4'd4) begin
            errors++; $display("FAIL coll_size got %0d, required 4", hist_size[0 +: 4]);
        end
    endtask

    task automatic test_reset_mid_read();
        rd_exp_t e;
        hist_addr                = {mk(3, 0), mk(5, 0), mk(2, 0), mk(7, 0)};
        hist_addr[3*AW +: AW]    = 8'h32;
        hist_wr_en               = '0;
        hist_rq                  = 4'b1000;
        #1;
        checks++;
        if (hist_access_grant !== 4'b1000) begin
            errors++; $display("FAIL mid_grant got %b, required 1000", hist_access_grant);
        end
        @(posedge clk); #1;
        rst     = 1'b1;
        hist_rq = '1;
        #1;
        checks++;
        if (hist_rd_vld !== 1'b0 || hist_access_grant !== 4'b0000) begin
            errors++;
            $display("FAIL mid_suppress got vld=%b grant=%b, required 0/0000", hist_rd_vld, hist_access_grant);
        end
        @(posedge clk); #1;
        checks++;
        if (hist_size !== 16'h0000 || hist_rd_vld !== 1'b0) begin
            errors++; $display("FAIL mid_state got size=%h vld=%b, required 0000/0", hist_size, hist_rd_vld);
        end
        rst = 1'b0;
        for (int l = 0; l < 8; l++) sz_m[l] = 4'd0;
        // Pointer back at NCORES-1: core 0 wins; RAM survived reset.
        for (int i = 0; i < NCORES; i++) hist_addr[i*AW +: AW] = 8'h32;
        #1;
        checks++;
        if (hist_access_grant !== 4'b0001) begin
            errors++; $display("FAIL post_rst_grant got %b, required 0001", hist_access_grant);
        end
        e.core = 0;
        e.data = mem_m[int'(8'h32)];
        sb.push_back(e);
        @(posedge clk); #1;
        hist_rq = '0;
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog expired");
        $fatal(1, "timeout");
    end

    initial begin
        rst          = 1'b1;
        hist_rq      = '0;
        hist_wr_en   = '0;
        hist_addr    = '0;
        hist_data_wr = '0;
        hist_clr     = 1'b0;
        hist_clr_lp  = '0;
        test_reset();
        test_two_req();
        test_fairness();
        test_write_read();
        test_saturation();
        test_clr_collision();
        test_reset_mid_read();
        repeat (3) @(posedge clk);
        #1;
        checks++;
        if (sb.size() != 0) begin
            errors++; $display("FAIL sb_drain got %0d pending reads, required 0", sb.size());
        end
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
